multiplier: RTL and testbench

// - Unsigned 16x16 -> 32-bit multiplier with one registered output stage.
// - Leaf arithmetic block driven by the multiplier UVM environment through multiplier_if.
// - The driver applies in1/in2 on the clock.
// - The monitor samples in1, in2 and out on each posedge.
// - The scoreboard compares each out against the previous cycle's inputs.
//

---
 rtl/multiplier_pkg.sv | 37 +++
 rtl/multiplier_if.sv | 15 +
 rtl/multiplier_booth_pp_gen.sv | 50 +++++
 rtl/multiplier.sv | 62 ++++++
 tb/tb_multiplier.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/multiplier_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
//   MULT_W / PROD_W : operand and product widths
//   operand_t       : unsigned operand
//   product_t       : full-width unsigned product
//   booth_digit_e   : recoded radix-4 Booth digit
//   csa_t / csa3    : one 3:2 carry-save compressor stage over product_t
package multiplier_pkg;

  localparam int MULT_W = 16;
  localparam int PROD_W = 2 * MULT_W;

  typedef logic [MULT_W-1:0] operand_t;
  typedef logic [PROD_W-1:0] product_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_e;

  typedef struct packed {
    product_t sum;
    product_t carry;
  } csa_t;

  // The carry is pre-shifted into its weight.
  // Bits carried past PROD_W are dropped because the final product always fits.
  function automatic csa_t csa3(product_t a, product_t b, product_t c);
    csa_t r;
    r.sum   = a ^ b ^ c;
    r.carry = ((a & b) | (a & c) | (b & c)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/multiplier_if.sv
// Operand/product bundle between a driver and the multiplier.
//   in1 : multiplicand, unsigned
//   in2 : multiplier, unsigned
//   out : registered product, unsigned
interface multiplier_if;
  import multiplier_pkg::*;

  operand_t in1;
  operand_t in2;
  product_t out;

  modport master (output in1, output in2, input out);
  modport slave  (input in1, input in2, output out);

endinterface

// File: rtl/multiplier_booth_pp_gen.sv
// One radix-4 Booth partial-product generator.
//   mcand_i : multiplicand
//   group_i : overlapping 3-bit group of the zero-extended multiplier
//   digit_o : recoded Booth digit
//   pp_o    : signed partial product, sign-extended to PROD_W and shifted into place
module booth_pp_gen
  import multiplier_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  operand_t     mcand_i,
  input  logic [2:0]   group_i,
  output booth_digit_e digit_o,
  output product_t     pp_o
);

  product_t mag;
  product_t pp_unshifted;

  always_comb begin
    digit_o = ZERO;
    unique case (group_i)
      3'b000, 3'b111: digit_o = ZERO;
      3'b001, 3'b010: digit_o = POS1;
      3'b011:         digit_o = POS2;
      3'b100:         digit_o = NEG2;
      3'b101, 3'b110: digit_o = NEG1;
      default:        digit_o = ZERO;
    endcase
  end

  always_comb begin
    mag          = '0;
    pp_unshifted = '0;
    case (digit_o)
      POS1, NEG1: mag = product_t'(mcand_i);
      POS2, NEG2: mag = product_t'(mcand_i) << 1;
      default:    mag = '0;
    endcase
    // Negation as a full-width two's complement.
    // The sign extension then comes for free, modulo 2^PROD_W.
    if (digit_o == NEG1 || digit_o == NEG2) begin
      pp_unshifted = ~mag + product_t'(1);
    end else begin
      pp_unshifted = mag;
    end
    pp_o = pp_unshifted << SHIFT;
  end

endmodule

// File: rtl/multiplier.sv
// Unsigned MULT_W x MULT_W -> PROD_W multiplier with one output register.
// The datapath is radix-4 Booth recoding, a 3:2 carry-save tree and one final adder.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low clear of the product register
//   bus   : in1/in2 operands in, out registered product
module multiplier
  import multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  multiplier_if.slave  bus
);

  // The multiplier is zero-extended by two bits so that the top digit is never negative.
  // One implicit zero is also placed below the LSB.
  localparam int NUM_PP = (WIDTH + 2) / 2;

  logic [WIDTH+2:0] mplier_pad;
  product_t         pp [NUM_PP];
  booth_digit_e     digit [NUM_PP];

  assign mplier_pad = {2'b00, bus.in2, 1'b0};

  for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
    booth_pp_gen #(.SHIFT(2 * i)) u_pp (
      .mcand_i (bus.in1),
      .group_i (mplier_pad[2*i+2 -: 3]),
      .digit_o (digit[i]),
      .pp_o    (pp[i])
    );
  end

  // Wallace-style reduction of the partial products.
  // The count shrinks 9 -> 6 -> 4 -> 3 -> 2.
  csa_t l1_0, l1_1, l1_2, l2_0, l2_1, l3, l4;

  assign l1_0 = csa3(pp[0], pp[1], pp[2]);
  assign l1_1 = csa3(pp[3], pp[4], pp[5]);
  assign l1_2 = csa3(pp[6], pp[7], pp[8]);
  assign l2_0 = csa3(l1_0.sum, l1_0.carry, l1_1.sum);
  assign l2_1 = csa3(l1_1.carry, l1_2.sum, l1_2.carry);
  assign l3   = csa3(l2_0.sum, l2_0.carry, l2_1.sum);
  assign l4   = csa3(l3.sum, l3.carry, l2_1.carry);

  product_t out_d;
  product_t out_q;

  assign out_d = l4.sum + l4.carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_multiplier.sv
module tb_multiplier;
  import multiplier_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  multiplier_if bus ();

  multiplier #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operands change 1 time unit after a posedge.
  // The output is sampled 1 time unit after the next posedge.
  task automatic test_reset();
    rst_n   = 1'b1;
    bus.in1 = 16'hFFFF;
    bus.in2 = 16'hFFFF;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: out=%h expected=%h", bus.out, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: out=%h expected=%h", i, bus.out, 32'h0);
      end
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release_sync: out=%h expected=%h", bus.out, 32'h0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out !== 32'hFFFE_0001) begin
      n_fail++;
      $display("FAIL reset_first_product: out=%h expected=%h", bus.out, 32'hFFFE_0001);
    end
  endtask

  task automatic test_corners();
    operand_t a [4] = '{16'h0000, 16'h0000, 16'h0001, 16'h8000};
    operand_t b [4] = '{16'h0000, 16'hFFFF, 16'h1234, 16'h0002};
    product_t e [4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_1234, 32'h0001_0000};
    product_t prev;
    prev = 32'hFFFE_0001;
    for (int i = 0; i < 4; i++) begin
      bus.in1 = a[i];
      bus.in2 = b[i];
      #1;
      n_checks++;
      if (bus.out !== prev) begin
        n_fail++;
        $display("FAIL corner_latency[%0d]: out=%h expected=%h", i, bus.out, prev);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.out !== e[i]) begin
        n_fail++;
        $display("FAIL corner[%0d]: out=%h expected=%h", i, bus.out, e[i]);
      end
      prev = e[i];
    end
  endtask

  task automatic test_booth_digits();
    operand_t b [3] = '{16'h5555, 16'hAAAA, 16'h7FFF};
    product_t e [3] = '{32'h0611_4F44, 32'h0C22_9E88, 32'h0919_EDCC};
    for (int i = 0; i < 3; i++) begin
      bus.in1 = 16'h1234;
      bus.in2 = b[i];
      @(posedge clk); #1;
      n_checks++;
      if (bus.out !== e[i]) begin
        n_fail++;
        $display("FAIL booth[%0d]: out=%h expected=%h", i, bus.out, e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    product_t exp_p;
    operand_t a, b;
    for (int i = 0; i < 1000; i++) begin
      a = operand_t'($urandom_range(0, 16'hFFFF));
      b = operand_t'($urandom_range(0, 16'hFFFF));
      bus.in1 = a;
      bus.in2 = b;
      exp_p = product_t'(a) * product_t'(b);
      @(posedge clk); #1;
      n_checks++;
      if (bus.out !== exp_p) begin
        n_fail++;
        $display("FAIL stream[%0d] %h*%h: out=%h expected=%h", i, a, b, bus.out, exp_p);
      end
    end
  endtask

  task automatic test_mid_reset();
    bus.in1 = 16'h00FF;
    bus.in2 = 16'h0101;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out !== 32'h0000_FFFF) begin
      n_fail++;
      $display("FAIL midrst_before: out=%h expected=%h", bus.out, 32'h0000_FFFF);
    end
    bus.in1 = 16'h4000;
    bus.in2 = 16'h0004;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_async: out=%h expected=%h", bus.out, 32'h0);
    end
    bus.in1 = 16'h0003;
    bus.in2 = 16'h0005;
    #4 rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.out !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_hold: out=%h expected=%h", bus.out, 32'h0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out !== 32'h0000_000F) begin
      n_fail++;
      $display("FAIL midrst_after: out=%h expected=%h", bus.out, 32'h0000_000F);
    end
  endtask

  task automatic test_max_operand();
    bus.in1 = 16'hFFFF;
    bus.in2 = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out !== 32'hFFFE_0001 || $isunknown(bus.out)) begin
        n_fail++;
        $display("FAIL max_operand[%0d]: out=%h expected=%h", i, bus.out, 32'hFFFE_0001);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_corners();
    test_booth_digits();
    test_back_to_back();
    test_mid_reset();
    test_max_operand();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
